// File: rtl/pdh_dma_pkg.sv
// Shared definitions for the PDH DMA read and write controllers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pdh_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [3:0]  BURST_LEN = 4'd15;    // ARLEN: 16 beats
  localparam logic [2:0]  BEAT_SIZE = 3'd3;     // ARSIZE: 8 bytes per beat
  localparam logic [1:0]  BURST_INC = 2'b01;    // ARBURST: INCR
  localparam logic [31:0] ADDR_INC  = 32'd128;  // bytes per burst
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [4:0]  LAST_BEAT = 5'd15;    // index of the final beat in a burst

endpackage

// File: rtl/dma_read_controller_if.sv
// AXI3 read-channel bundle (AR + R) between the DMA read master and the HP port.
// Latency: n/a (wires only).
// Backpressure: arvalid/arready and rvalid/rready handshakes carried unchanged.
// master: drives AR channel and rready. slave: drives arready and the R channel.
interface dma_read_controller_if;

  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;

  modport master (
    output m_axi_araddr, m_axi_arvalid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rresp, m_axi_rlast
  );

  modport slave (
    input  m_axi_araddr, m_axi_arvalid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rresp, m_axi_rlast
  );

endinterface

// File: rtl/posedge_detector.sv
// Rising-edge detector for a synchronous level.
// Latency: combinational pulse in the cycle the level is first seen high.
// Backpressure: none.  Ports: aclk, rst_i (async active-high), d (level), pulse (1-cycle).
module posedge_detector (
  input  logic aclk,
  input  logic rst_i,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/sync_3ff.sv
// Three-flop synchronizer for a single asynchronous level into the aclk domain.
// Latency: 3 aclk.  Backpressure: none.
// Ports: aclk, rst_i (async active-high), d (async level), q (synchronized level).
module sync_3ff (
  input  logic aclk,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [2:0] sync_ff;

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      sync_ff <= 3'b000;
    end else begin
      sync_ff <= {sync_ff[1:0], d};
    end
  end

  assign q = sync_ff[2];

endmodule

// File: rtl/dma_read_controller.sv
// AXI3 read master: reads DMA_SIZE bytes from HP0_BASE_ADDR in 16x64-bit bursts into a BRAM port.
// Latency: first arvalid 4 aclk after the enable_i edge; BRAM write 1 aclk after each accepted beat.
// Backpressure: holds AR stable until arready; rready high for the whole burst, one burst outstanding.
// Ports: aclk, rst_i (async active-high); axi (AXI read master); enable_i (async start);
//        dma_ready_o/dma_done_o/dma_error_o status; bram_we_o/bram_addr_o/bram_data_o write port.
module dma_read_controller
  import pdh_dma_pkg::*;
#(
  parameter logic [31:0] HP0_BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] DMA_SIZE      = 32'h0002_0000,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                         aclk,
  input  logic                         rst_i,
  dma_read_controller_if.master        axi,
  input  logic                         enable_i,
  output logic                         dma_ready_o,
  output logic                         dma_done_o,
  output logic                         dma_error_o,
  output logic                         bram_we_o,
  output logic [31:0]                  bram_addr_o,
  output logic [63:0]                  bram_data_o
);

  localparam logic [31:0] LAST_BYTE   = HP0_BASE_ADDR + DMA_SIZE - 32'd1;
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

  // Reset asserts asynchronously, releases two aclk edges after rst_i falls.
  logic [1:0] rst_pipe;
  logic       rst_int;

  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst_int = rst_pipe[1];

  // Start detection
  logic enable_sync;
  logic enable_rise;

  sync_3ff u_enable_sync (
    .aclk  (aclk),
    .rst_i (rst_int),
    .d     (enable_i),
    .q     (enable_sync)
  );

  posedge_detector u_enable_edge (
    .aclk  (aclk),
    .rst_i (rst_int),
    .d     (enable_sync),
    .pulse (enable_rise)
  );

  // The synchronizer comes out of reset holding zeros, so an enable_i that was
  // already high would look like a fresh edge. Starts are only accepted once the
  // pipeline carries real samples and enable has been seen low at least once.
  logic [1:0] warm_cnt;
  logic       armed;
  logic       start;

  always_ff @(posedge aclk or posedge rst_int) begin
    if (rst_int) begin
      warm_cnt <= 2'd0;
      armed    <= 1'b0;
    end else begin
      if (warm_cnt != 2'd3) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
      if (warm_cnt == 2'd3 && !enable_sync) begin
        armed <= 1'b1;
      end
    end
  end

  // Main FSM and datapath
  state_t      state;
  logic [31:0] araddr;
  logic [4:0]  beat;
  logic [7:0]  retry_cnt;
  logic        burst_bad;

  logic        beat_bad;
  logic        burst_end;
  logic        burst_ok;
  logic        last_burst;
  logic [31:0] word_base;

  assign start      = enable_rise & armed & (state == ST_IDLE);
  assign beat_bad   = burst_bad | (axi.m_axi_rresp != RESP_OKAY);
  // A burst ends on rlast or after the 16th beat; early rlast or a missing rlast are bad bursts.
  assign burst_end  = axi.m_axi_rlast | (beat == LAST_BEAT);
  assign burst_ok   = !beat_bad && axi.m_axi_rlast && (beat == LAST_BEAT);
  assign last_burst = (araddr + ADDR_INC) > LAST_BYTE;
  assign word_base  = (araddr - HP0_BASE_ADDR) >> 3;

  always_ff @(posedge aclk or posedge rst_int) begin
    if (rst_int) begin
      state       <= ST_IDLE;
      araddr      <= HP0_BASE_ADDR;
      beat        <= 5'd0;
      retry_cnt   <= 8'd0;
      burst_bad   <= 1'b0;
      bram_we_o   <= 1'b0;
      bram_addr_o <= 32'd0;
      bram_data_o <= 64'd0;
      dma_done_o  <= 1'b0;
      dma_error_o <= 1'b0;
    end else begin
      bram_we_o  <= 1'b0;
      dma_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            araddr      <= HP0_BASE_ADDR;
            dma_error_o <= 1'b0;
            retry_cnt   <= 8'd0;
            state       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (axi.m_axi_arready) begin
            beat      <= 5'd0;
            burst_bad <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (axi.m_axi_rvalid) begin
            bram_we_o   <= 1'b1;
            bram_data_o <= axi.m_axi_rdata;
            bram_addr_o <= word_base + {27'd0, beat};
            beat        <= beat + 5'd1;
            burst_bad   <= beat_bad;
            if (burst_end) begin
              if (burst_ok) begin
                retry_cnt <= 8'd0;
                if (last_burst) begin
                  dma_done_o <= 1'b1;
                  state      <= ST_IDLE;
                end else begin
                  araddr <= araddr + ADDR_INC;
                  state  <= ST_ADDR;
                end
              end else if (retry_cnt < RETRY_LIMIT) begin
                // Same address again; the retried beats overwrite the bad ones.
                retry_cnt <= retry_cnt + 8'd1;
                state     <= ST_ADDR;
              end else begin
                dma_error_o <= 1'b1;
                state       <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dma_ready_o       = (state == ST_IDLE);
  assign axi.m_axi_araddr  = araddr;
  assign axi.m_axi_arvalid = (state == ST_ADDR);
  assign axi.m_axi_rready  = (state == ST_DATA);
  assign axi.m_axi_arlen   = BURST_LEN;
  assign axi.m_axi_arsize  = BEAT_SIZE;
  assign axi.m_axi_arburst = BURST_INC;

endmodule

// File: tb/tb_dma_read_controller.sv
// Bench for dma_read_controller: memory model on the AXI read port, scoreboard on BRAM writes.
// Latency: n/a.  Backpressure: model can delay arready and insert random rvalid gaps.
module tb_dma_read_controller;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SIZE = 32'd256;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  logic        aclk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        dma_ready_o, dma_done_o, dma_error_o, bram_we_o;
  logic [31:0] bram_addr_o;
  logic [63:0] bram_data_o;

  dma_read_controller_if axi ();

  dma_read_controller #(
    .HP0_BASE_ADDR (BASE),
    .DMA_SIZE      (SIZE),
    .MAX_RETRY     (3)
  ) dut (
    .aclk        (aclk),
    .rst_i       (rst_i),
    .axi         (axi),
    .enable_i    (enable_i),
    .dma_ready_o (dma_ready_o),
    .dma_done_o  (dma_done_o),
    .dma_error_o (dma_error_o),
    .bram_we_o   (bram_we_o),
    .bram_addr_o (bram_addr_o),
    .bram_data_o (bram_data_o)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboards
  logic [31:0] exp_ar[$];
  wr_t         exp_wr[$];
  logic [63:0] mirror[32];
  int          wr_cnt;
  int          done_cnt;

  // Memory model configuration
  int          ar_delay;
  bit          gaps;
  logic [31:0] err_addr;
  int          err_beat, err_times, err_att;
  logic [31:0] early_addr;
  int          early_beat, early_times, early_att;

  task automatic cfg(input int dly, input bit gp, input logic [31:0] ea, input int eb, input int et,
                     input logic [31:0] la, input int lb, input int lt);
    ar_delay = dly; gaps = gp;
    err_addr = ea; err_beat = eb; err_times = et; err_att = 0;
    early_addr = la; early_beat = lb; early_times = lt; early_att = 0;
  endtask

  // Memory model: data = byte address, configurable errors / early rlast
  bit          s_ar_hs, s_r_hs, s_arvalid;
  logic [31:0] s_araddr;
  bit          ar_pending, ar_drop, active, cur_err, cur_early, was_last;
  logic [31:0] ar_first, cur_addr, ea;
  int          ar_wait, beat_i;

  initial begin : mem_model
    axi.m_axi_arready = 1'b0;
    axi.m_axi_rvalid  = 1'b0;
    axi.m_axi_rlast   = 1'b0;
    axi.m_axi_rresp   = 2'b00;
    axi.m_axi_rdata   = 64'd0;
    ar_pending = 0; active = 0; ar_wait = 0; beat_i = 0;
    forever begin
      @(negedge aclk);
      s_ar_hs   = axi.m_axi_arvalid && axi.m_axi_arready;
      s_r_hs    = axi.m_axi_rvalid && axi.m_axi_rready;
      s_arvalid = axi.m_axi_arvalid;
      s_araddr  = axi.m_axi_araddr;
      @(posedge aclk);
      #1;
      if (rst_i) begin
        axi.m_axi_arready = 1'b0;
        axi.m_axi_rvalid  = 1'b0;
        axi.m_axi_rlast   = 1'b0;
        axi.m_axi_rresp   = 2'b00;
        active = 0; ar_pending = 0; ar_wait = 0;
        exp_ar.delete();
        exp_wr.delete();
      end else begin
        if (ar_pending && !s_arvalid) ar_drop = 1;
        if (s_arvalid && !ar_pending) begin
          ar_pending = 1; ar_first = s_araddr; ar_drop = 0; ar_wait = 0;
        end
        if (s_ar_hs) begin
          chk("ar_stable", s_araddr, ar_first);
          chk("ar_held", ar_drop, 0);
          if (exp_ar.size() > 0) ea = exp_ar.pop_front();
          else ea = 32'hDEAD_BEEF;
          chk("ar_addr", s_araddr, ea);
          ar_pending = 0;
          axi.m_axi_arready = 1'b0;
          cur_addr = ea; beat_i = 0; active = 1;
          if (cur_addr == err_addr) err_att++;
          if (cur_addr == early_addr) early_att++;
          cur_err   = (cur_addr == err_addr) && (err_att <= err_times);
          cur_early = (cur_addr == early_addr) && (early_att <= early_times);
        end else if (ar_pending && !active) begin
          if (ar_wait >= ar_delay) axi.m_axi_arready = 1'b1;
          else ar_wait++;
        end
        if (s_r_hs) begin
          exp_wr.push_back({((cur_addr - BASE) >> 3) + 32'(beat_i), {32'd0, cur_addr + 32'(8 * beat_i)}});
          was_last = axi.m_axi_rlast;
          beat_i++;
          axi.m_axi_rvalid = 1'b0;
          axi.m_axi_rlast  = 1'b0;
          axi.m_axi_rresp  = 2'b00;
          if (was_last) active = 0;
        end
        if (active && !axi.m_axi_rvalid) begin
          if (!(gaps && $urandom_range(0, 2) == 0)) begin
            axi.m_axi_rvalid = 1'b1;
            axi.m_axi_rdata  = {32'd0, cur_addr + 32'(8 * beat_i)};
            axi.m_axi_rresp  = (cur_err && beat_i == err_beat) ? 2'b10 : 2'b00;
            axi.m_axi_rlast  = (beat_i == (cur_early ? early_beat : 15));
          end
        end
      end
    end
  end

  // BRAM write monitor
  wr_t mw;
  initial begin : wr_monitor
    forever begin
      @(negedge aclk);
      if (bram_we_o) begin
        if (exp_wr.size() > 0) mw = exp_wr.pop_front();
        else mw = {32'hFFFF_FFFF, 64'hDEAD_BEEF_DEAD_BEEF};
        chk("wr_addr", bram_addr_o, mw.addr);
        chk("wr_data", bram_data_o, mw.data);
        wr_cnt++;
        if (bram_addr_o < 32) mirror[bram_addr_o[4:0]] = bram_data_o;
      end
      if (dma_done_o) done_cnt++;
    end
  end

  task automatic run_test(input int n_wr, input bit exp_done, input bit exp_err);
    int n;
    int good;
    done_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < 32; i++) mirror[i] = 64'd0;
    enable_i = 1'b1;
    n = 0;
    do begin
      @(posedge aclk);
      #1;
      n++;
    end while (!axi.m_axi_arvalid && n < 20);
    chk("start_latency", n, 4);
    chk("ready_busy", dma_ready_o, 0);
    chk("err_cleared", dma_error_o, 0);
    n = 0;
    while (!dma_ready_o && n < 3000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("finish_in_time", n < 3000, 1);
    // enable_i still high: returning to idle must not restart
    repeat (10) @(posedge aclk);
    #1;
    chk("no_restart", dma_ready_o, 1);
    enable_i = 1'b0;
    repeat (8) @(posedge aclk);
    #1;
    chk("done_cnt", done_cnt, exp_done);
    chk("error", dma_error_o, exp_err);
    chk("wr_cnt", wr_cnt, n_wr);
    chk("ar_left", exp_ar.size(), 0);
    chk("ready_idle", dma_ready_o, 1);
    if (exp_done) begin
      good = 0;
      for (int i = 0; i < 32; i++) if (mirror[i] == {32'd0, BASE + 32'(8 * i)}) good++;
      chk("bram_image", good, 32);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  int n;
  int arv_cnt;

  initial begin : main
    cfg(0, 0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0, 0);
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arvalid", axi.m_axi_arvalid, 0);
    chk("rst_rready", axi.m_axi_rready, 0);
    chk("rst_ready", dma_ready_o, 1);
    chk("rst_done", dma_done_o, 0);
    chk("rst_error", dma_error_o, 0);
    chk("rst_we", bram_we_o, 0);
    chk("rst_bram_addr", bram_addr_o, 0);
    chk("rst_bram_data", bram_data_o, 0);
    chk("rst_araddr", axi.m_axi_araddr, BASE);
    chk("arlen", axi.m_axi_arlen, 15);
    chk("arsize", axi.m_axi_arsize, 3);
    chk("arburst", axi.m_axi_arburst, 1);
    rst_i = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    chk("post_rst_ready", dma_ready_o, 1);

    // Basic transfer
    exp_ar.push_back(BASE); exp_ar.push_back(BASE + 32'h80);
    run_test(32, 1, 0);

    // Delayed arready and random rvalid gaps
    cfg(5, 1, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0, 0);
    exp_ar.push_back(BASE); exp_ar.push_back(BASE + 32'h80);
    run_test(32, 1, 0);

    // SLVERR on beat 7 of burst 0, first attempt only
    cfg(0, 0, BASE, 7, 1, 32'hFFFF_FFFF, 0, 0);
    exp_ar.push_back(BASE); exp_ar.push_back(BASE); exp_ar.push_back(BASE + 32'h80);
    run_test(48, 1, 0);

    // Burst 1 always fails: 1 + MAX_RETRY attempts, then abort
    cfg(0, 0, BASE + 32'h80, 3, 1000, 32'hFFFF_FFFF, 0, 0);
    exp_ar.push_back(BASE);
    for (int i = 0; i < 4; i++) exp_ar.push_back(BASE + 32'h80);
    run_test(80, 0, 1);

    // rlast on beat 9 of burst 0 (first attempt); also clears the sticky error
    cfg(1, 0, 32'hFFFF_FFFF, 0, 0, BASE, 9, 1);
    exp_ar.push_back(BASE); exp_ar.push_back(BASE); exp_ar.push_back(BASE + 32'h80);
    run_test(42, 1, 0);

    // Reset while beat 5 of burst 0 is on the bus
    cfg(0, 0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 0, 0);
    exp_ar.push_back(BASE); exp_ar.push_back(BASE + 32'h80);
    enable_i = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!(axi.m_axi_rvalid && axi.m_axi_rready && axi.m_axi_rdata[31:0] == BASE + 32'd40) && n < 200);
    chk("beat5_reached", n < 200, 1);
    chk("pre_rst_rready", axi.m_axi_rready, 1);
    chk("pre_rst_we", bram_we_o, 1);
    #1 rst_i = 1'b1;
    #1;
    chk("midrst_rready", axi.m_axi_rready, 0);
    chk("midrst_arvalid", axi.m_axi_arvalid, 0);
    chk("midrst_we", bram_we_o, 0);
    chk("midrst_ready", dma_ready_o, 1);
    repeat (3) @(posedge aclk);
    #1 rst_i = 1'b0;
    arv_cnt = 0;
    repeat (30) begin
      @(negedge aclk);
      if (axi.m_axi_arvalid) arv_cnt++;
    end
    chk("held_enable_no_start", arv_cnt, 0);
    chk("after_rst_ready", dma_ready_o, 1);
    enable_i = 1'b0;
    repeat (8) @(posedge aclk);
    #1;

    // A fresh edge after reset runs a clean transfer
    exp_ar.push_back(BASE); exp_ar.push_back(BASE + 32'h80);
    run_test(32, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
